// File: rtl/sd_spi_xfer.sv
// rtl/sd_spi_xfer.sv - SPI-mode SD card single-block (64-bit) read/write transfer engine
//
// Builds and shifts out CMD17 (read) or CMD24 (write) with CRC7, then parses
// R1, the data token, the data block, CRC16 and (for writes) the data response
// and busy phase. One SPI bit moves per rising edge of clk_i.
//
// Ports:
//   clk_i      system clock, one SPI bit per rising edge
//   rst_i      synchronous active-high reset
//   start_i    one-cycle request pulse, ignored while busy
//   dir_i      0 = write card (CMD24), 1 = read card (CMD17), sampled with start_i
//   addr_i     16-bit block address, zero-extended into the command argument
//   wr_data_i  64-bit block to write, MSB first, sampled with start_i
//   rd_data_o  last block read without error, valid with done_o
//   busy_o     transfer in progress
//   done_o     one-cycle completion pulse
//   err_o      qualifies done_o: abort, timeout or check failure
//   mosi_o     serial data to card, idles high
//   miso_i     serial data from card, idles high
//
// Build option: define SD_RD_CRC_CHECK_EN to verify the CRC16 of read blocks.

module sd_spi_xfer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [15:0] addr_i,
  input  logic [63:0] wr_data_i,
  output logic [63:0] rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_WAIT_R1, S_R1, S_WAIT_TOKEN, S_RDATA, S_RCRC, S_GAP,
    S_WTOKEN, S_WDATA, S_WCRC, S_WAIT_DRESP, S_DRESP, S_WBUSY, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  // CRC7, polynomial x^7+x^3+1, init 0, MSB first
  function automatic logic [6:0] crc7_f(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // CRC16-CCITT, polynomial x^16+x^12+x^5+1, init 0, MSB first
  function automatic logic [15:0] crc16_f(input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = '0;
    for (int i = 63; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [87:0] tx_q, tx_d;
  logic [63:0] rx_q, rx_d;
  logic [63:0] rd_q, rd_d;
  logic [63:0] wr_q, wr_d;
  logic        dir_q, dir_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, done_q, err_q;
`ifdef SD_RD_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d;
`endif

  logic [5:0]  cmd_w;
  logic [39:0] cmd_hdr_w;
  logic [47:0] frame_w;
  logic [87:0] wr_frame_w;

  assign cmd_w      = dir_i ? 6'd17 : 6'd24;
  assign cmd_hdr_w  = {2'b01, cmd_w, 16'h0000, addr_i};
  assign frame_w    = {cmd_hdr_w, crc7_f(cmd_hdr_w), 1'b1};
  assign wr_frame_w = {8'hFE, wr_q, crc16_f(wr_q)};
  assign cnt_inc    = cnt_q + 16'd1;

  // The transmit register is refilled with ones as it drains, so the bit
  // presented after the last frame bit is already the idle-high level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dir_d   = dir_q;
    mosi_d  = 1'b1;
`ifdef SD_RD_CRC_CHECK_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mosi_d  = frame_w[47];
          tx_d    = {frame_w[46:0], {41{1'b1}}};
          dir_d   = dir_i;
          wr_d    = wr_data_i;
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD, S_WTOKEN, S_WDATA, S_WCRC: begin
        mosi_d = tx_q[87];
        tx_d   = {tx_q[86:0], 1'b1};
        cnt_d  = cnt_inc;
        if (state_q == S_CMD && cnt_q == 16'd47) begin
          state_d = S_WAIT_R1;
          cnt_d   = '0;
        end else if (state_q == S_WTOKEN && cnt_q == 16'd7) begin
          state_d = S_WDATA;
          cnt_d   = '0;
        end else if (state_q == S_WDATA && cnt_q == 16'd63) begin
          state_d = S_WCRC;
          cnt_d   = '0;
        end else if (state_q == S_WCRC && cnt_q == 16'd15) begin
          state_d = S_WAIT_DRESP;
          cnt_d   = '0;
        end
      end
      S_WAIT_R1, S_WAIT_TOKEN, S_WAIT_DRESP: begin
        if (!miso_i) begin
          cnt_d = '0;
          rx_d  = '0;
          case (state_q)
            S_WAIT_R1:    state_d = S_R1;
            S_WAIT_TOKEN: state_d = S_RDATA;
            default:      state_d = S_DRESP;
          endcase
        end else if (cnt_inc == TMO) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_R1, S_DRESP: begin
        // The leading zero was consumed by the wait state; 7 bits remain.
        rx_d  = {rx_q[62:0], miso_i};
        cnt_d = cnt_inc;
        if (cnt_q == 16'd6) begin
          cnt_d = '0;
          if (state_q == S_R1)
            state_d = ({rx_q[5:0], miso_i} != 7'd0) ? S_ERR :
                      (dir_q ? S_WAIT_TOKEN : S_GAP);
          else
            state_d = ({rx_q[5:0], miso_i} == 7'b0000101) ? S_WBUSY : S_ERR;
        end
      end
      S_RDATA: begin
        rx_d  = {rx_q[62:0], miso_i};
        cnt_d = cnt_inc;
        if (cnt_q == 16'd63) begin
          state_d = S_RCRC;
          cnt_d   = '0;
        end
      end
      S_RCRC: begin
        cnt_d = cnt_inc;
`ifdef SD_RD_CRC_CHECK_EN
        crc_d = {crc_q[14:0], miso_i};
`endif
        if (cnt_q == 16'd15) begin
          cnt_d = '0;
`ifdef SD_RD_CRC_CHECK_EN
          if ({crc_q[14:0], miso_i} == crc16_f(rx_q)) begin
            state_d = S_DONE;
            rd_d    = rx_q;
          end else begin
            state_d = S_ERR;
          end
`else
          state_d = S_DONE;
          rd_d    = rx_q;
`endif
        end
      end
      S_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == 16'd7) begin
          mosi_d  = wr_frame_w[87];
          tx_d    = {wr_frame_w[86:0], 1'b1};
          cnt_d   = '0;
          state_d = S_WTOKEN;
        end
      end
      S_WBUSY: begin
        if (miso_i)                state_d = S_DONE;
        else if (cnt_inc == TMO)   state_d = S_ERR;
        else                       cnt_d   = cnt_inc;
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tx_q    <= '1;
      rx_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      dir_q   <= 1'b0;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SD_RD_CRC_CHECK_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      mosi_q  <= mosi_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE) || (state_d == S_ERR);
      err_q   <= (state_d == S_ERR);
`ifdef SD_RD_CRC_CHECK_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign rd_data_o = rd_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_sd_spi_xfer.sv
// tb/tb_sd_spi_xfer.sv - self-checking bench for sd_spi_xfer with a scripted SD card model
module tb_sd_spi_xfer;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_i, start_i, dir_i, miso_i;
  logic [15:0] addr_i;
  logic [63:0] wr_data_i, rd_data_o;
  logic        busy_o, done_o, err_o, mosi_o;

  always #5 clk = ~clk;

  sd_spi_xfer #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i),
    .addr_i(addr_i), .wr_data_i(wr_data_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mosi_o(mosi_o), .miso_i(miso_i)
  );

  int          checks = 0;
  int          failures = 0;
  logic [63:0] rd_model;
  logic [47:0] cap_frame;
  logic [63:0] cap_data;

  // Remainders by polynomial long division of the message times x^n.
  function automatic logic [6:0] m_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [15:0] m_crc16(input logic [63:0] m);
    logic [79:0] r;
    r = {m, 16'd0};
    for (int i = 79; i >= 16; i--)
      if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One transfer against a card whose MISO stream is scripted per cycle.
  // Cycle c is the interval ending at the c-th rising edge after start.
  task automatic xfer(input string tag, input bit d, input logic [15:0] a,
                      input logic [63:0] wd, input logic [63:0] cd, input logic [7:0] r1,
                      input int w1, input int w2, input int wb, input bit bad_crc,
                      input logic [7:0] dresp, input bit hang, input int xs,
                      input bit sod, input int rst_at);
    logic        ms [0:1199];
    logic        em [0:1199];
    logic [47:0] fr, cfr;
    logic [87:0] ws;
    logic [63:0] cdat;
    logic [15:0] ccrc;
    logic [7:0]  tok;
    logic [5:0]  cmd;
    int          p, done_exp, done_c, mis, busy_bad, ndone;
    bit          err_exp, err_c, rd_ok;
    tok = 8'hFE;
    cmd = d ? 6'd17 : 6'd24;
    cfr = '0; cdat = '0; ws = '0;
    for (int i = 0; i < 1200; i++) begin ms[i] = 1'b1; em[i] = 1'b1; end
    fr = {2'b01, cmd, 16'h0, a, m_crc7({2'b01, cmd, 16'h0, a}), 1'b1};
    for (int i = 0; i < 48; i++) em[1+i] = fr[47-i];
    err_exp = 0; rd_ok = 0; done_exp = 0;
    if (hang) begin
      done_exp = 49 + TMO; err_exp = 1;
    end else begin
      p = 49 + w1;
      for (int i = 0; i < 8; i++) ms[p+i] = r1[7-i];
      p += 8;
      if (r1 != 8'h00) begin
        done_exp = p; err_exp = 1;
      end else if (d) begin
        p += w2;
        for (int i = 0; i < 8; i++) ms[p+i] = tok[7-i];
        p += 8;
        for (int i = 0; i < 64; i++) ms[p+i] = cd[63-i];
        p += 64;
        ccrc = m_crc16(cd) ^ (bad_crc ? 16'h0100 : 16'h0000);
        for (int i = 0; i < 16; i++) ms[p+i] = ccrc[15-i];
        p += 16;
        done_exp = p;
`ifdef SD_RD_CRC_CHECK_EN
        err_exp = bad_crc;
`else
        err_exp = 0;
`endif
        rd_ok = !err_exp;
      end else begin
        ws = {8'hFE, wd, m_crc16(wd)};
        for (int i = 0; i < 88; i++) em[65+w1+i] = ws[87-i];
        p += 96 + w2;
        for (int i = 0; i < 8; i++) ms[p+i] = dresp[7-i];
        p += 8;
        if (dresp != 8'h05) begin
          done_exp = p; err_exp = 1;
        end else begin
          for (int i = 0; i < wb; i++) ms[p+i] = 1'b0;
          p += wb;
          done_exp = p + 1;
        end
      end
    end

    @(negedge clk);
    start_i = 1'b1; dir_i = d; addr_i = a; wr_data_i = wd; miso_i = 1'b1;
    done_c = 0; err_c = 0; mis = 0; busy_bad = 0; ndone = 0;
    for (int c = 1; c < 1200; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (rst_at > 0) begin
        if (c <= rst_at && mosi_o !== em[c]) mis++;
        if (c == rst_at) rst_i = 1'b1;
        if (c == rst_at + 1) begin
          chk({tag, ".rst_mosi"}, 64'(mosi_o), 64'd1);
          chk({tag, ".rst_busy"}, 64'(busy_o), 64'd0);
          chk({tag, ".rst_done"}, 64'(done_o), 64'd0);
          rst_i = 1'b0;
        end
        if (c > rst_at && done_o) ndone++;
        if (c == rst_at + 20) break;
      end else if (done_c == 0) begin
        if (mosi_o !== em[c]) mis++;
        if (busy_o !== 1'b1) busy_bad++;
        if (c <= 48) cfr[48-c] = mosi_o;
        if (c >= 73 + w1 && c <= 136 + w1) cdat[136+w1-c] = mosi_o;
        if (done_o) begin
          done_c = c; err_c = err_o;
          if (sod) start_i = 1'b1;
        end
      end else begin
        if (mosi_o !== em[c]) mis++;
        chk({tag, ".busy_after_done"}, 64'(busy_o), 64'd0);
        chk({tag, ".done_one_cycle"}, 64'(done_o), 64'd0);
        break;
      end
      miso_i = ms[c];
      if (c == xs) begin start_i = 1'b1; dir_i = ~d; addr_i = ~a; end
    end
    miso_i = 1'b1;
    cap_frame = cfr;
    cap_data  = cdat;

    if (rst_at > 0) begin
      rd_model = '0;
      chk({tag, ".mosi_before_rst"}, 64'(mis), 64'd0);
      chk({tag, ".no_done_after_rst"}, 64'(ndone), 64'd0);
      chk({tag, ".rd_after_rst"}, rd_data_o, rd_model);
    end else begin
      if (rd_ok) rd_model = cd;
      chk({tag, ".done_cycle"}, 64'(done_c), 64'(done_exp));
      chk({tag, ".err"}, 64'(err_c), 64'(err_exp));
      chk({tag, ".mosi_stream"}, 64'(mis), 64'd0);
      chk({tag, ".busy_span"}, 64'(busy_bad), 64'd0);
      chk({tag, ".rd_data"}, rd_data_o, rd_model);
      chk({tag, ".cmd_frame"}, 64'(cfr), 64'(fr));
      if (!d && r1 == 8'h00 && !hang) chk({tag, ".card_stored"}, cdat, wd);
    end
  endtask

  initial begin
    bit          d;
    logic [15:0] a;
    logic [63:0] wd, cd;
    rst_i = 1'b1; start_i = 1'b0; dir_i = 1'b0; addr_i = '0;
    wr_data_i = '0; miso_i = 1'b1; rd_model = '0;
    repeat (3) @(negedge clk);
    chk("reset.mosi", 64'(mosi_o), 64'd1);
    chk("reset.busy", 64'(busy_o), 64'd0);
    chk("reset.done", 64'(done_o), 64'd0);
    chk("reset.err", 64'(err_o), 64'd0);
    chk("reset.rd_data", rd_data_o, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    xfer("read0", 1, 16'h0000, 64'h0, 64'h0123456789ABCDEF, 8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0, 0);
    chk("read0.frame_const", 64'(cap_frame), 64'h510000000055);
    chk("read0.rd_const", rd_data_o, 64'h0123456789ABCDEF);

    xfer("write0", 0, 16'h1234, 64'hDEADBEEF00C0FFEE, 64'h0, 8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0, 0);
    chk("write0.frame_const", 64'(cap_frame[47:8]), 64'h5800001234);
    chk("write0.data_const", cap_data, 64'hDEADBEEF00C0FFEE);

    xfer("r1err", 1, 16'h0042, 64'h0, 64'hFFFF0000FFFF0000, 8'h04, 2, 0, 0, 0, 8'h05, 0, 0, 0, 0);
    chk("r1err.mosi_idle", 64'(mosi_o), 64'd1);

    xfer("timeout", 1, 16'h0007, 64'h0, 64'h0, 8'h00, 0, 0, 0, 0, 8'h05, 1, 0, 0, 0);

    xfer("r1_last_wait", 1, 16'h00A5, 64'h0, 64'h55AA55AA12345678, 8'h00, TMO - 1, 1, 0, 0, 8'h05, 0, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      d  = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      wd = {$urandom, $urandom};
      cd = {$urandom, $urandom};
      xfer($sformatf("rand%0d", k), d, a, wd, cd, 8'h00, $urandom_range(0, 6),
           $urandom_range(0, 6), $urandom_range(0, 5), 0, 8'h05, 0, 0, 0, 0);
    end

    xfer("badcrc", 1, 16'h0100, 64'h0, 64'hCAFEF00DDEADC0DE, 8'h00, 1, 2, 0, 1, 8'h05, 0, 0, 0, 0);

    xfer("baddresp", 0, 16'h0200, 64'h0F0F0F0FF0F0F0F0, 64'h0, 8'h00, 0, 3, 0, 0, 8'h0B, 0, 0, 0, 0);

    xfer("start_busy_rd", 1, 16'h0300, 64'h0, 64'h1122334455667788, 8'h00, 1, 1, 0, 0, 8'h05, 0, 20, 1, 0);
    xfer("start_busy_wr", 0, 16'h0400, 64'h8877665544332211, 64'h0, 8'h00, 2, 1, 4, 0, 8'h05, 0, 100, 1, 0);

    xfer("rst_mid_write", 0, 16'h0500, 64'hA5A5A5A55A5A5A5A, 64'h0, 8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0, 73 + 30);

    xfer("after_rst", 1, 16'h0600, 64'h0, 64'h0BADBEEF0BADBEEF, 8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_spi_xfer.md
# sd_spi_xfer

SPI-mode SD-card transfer engine for the DRAM↔SD bridge. It moves one 64-bit data block per request between the bridge datapath and the card's MOSI/MISO pins. It builds and shifts out CMD17 (single-block read) or CMD24 (single-block write) with CRC7, then parses R1, the data token, the CRC16 and the data response. The bridge's AXI/DRAM side feeds `wr_data` and consumes `rd_data`; the card (or `pseudo_SD`) sits directly on `MOSI`/`MISO`.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in any wait-for-card state before aborting with `err`.
- `clk` in 1: system clock; one SPI bit per rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request pulse; ignored while `busy`.
- `dir` in 1: 0 = write SD (CMD24), 1 = read SD (CMD17); sampled with `start`.
- `addr` in 16: SD block address, zero-extended to the 32-bit command argument; sampled with `start`.
- `wr_data` in 64: block to write, MSB first; sampled with `start`.
- `rd_data` out 64: block read from the card; valid with `done`, held until the next `done`.
- `busy` out 1: high from the cycle after `start` until the cycle after `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done` (1 = abort or check failure).
- `MOSI` out 1: serial data to card; idles high.
- `MISO` in 1: serial data from card; idles high.

## Operation
- Reset values: `MOSI`=1, `busy`=0, `done`=0, `err`=0, `rd_data`=0, FSM=IDLE. `rst` mid-transfer aborts immediately: no `done` pulse, `MOSI` returns high.
- IDLE --start--> CMD: shift 48-bit frame `01`, cmd[5:0] (17 or 24), arg[31:0], CRC7[6:0], `1`.
  - CRC7 polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
- CMD → WAIT_R1: the first sampled MISO=0 is R1 bit7. Then R1 shifts 7 more bits; R1≠0x00 → ERR.
- Read path:
  - WAIT_TOKEN: the first MISO=0 is the final bit of token 0xFE.
  - RDATA: 64 bits into `rd_data`, MSB first.
  - RCRC: 16 bits.
  - DONE.
- Write path:
  - GAP: 8 cycles of MOSI=1.
  - WTOKEN: 0xFE.
  - WDATA: 64 bits.
  - WCRC: CRC16-CCITT (x^16+x^12+x^5+1, init 0) over the data.
  - WAIT_DRESP: the first MISO=0 starts an 8-bit response. DRESP samples the remaining 7 bits; the byte must equal 8'b00000101, else ERR.
  - WBUSY: wait until MISO samples 1.
  - DONE.
- `MOSI`=1 in every state except CMD, WTOKEN, WDATA and WCRC.
- Each WAIT_* state and WBUSY has its own counter. The counter reaching `TIMEOUT` goes → ERR.
- DONE and ERR both last one cycle, then go → IDLE.
  - DONE pulses `done`=1, `err`=0.
  - ERR pulses `done`=1, `err`=1.
  - `rd_data` is updated only on error-free read completion.
- `start` while `busy`: ignored, no queueing. `start` in the same cycle as `done`: ignored.

## Timing
- `MOSI` is registered. CMD bit0 (`0`) appears on `MOSI` in the cycle after `start`; the frame occupies cycles 1..48.
- `MISO` is sampled on every rising edge. The earliest R1 bit7 is sampled in cycle 49.
- Read with zero wait cycles: 48 cmd + 8 R1 + 8 token + 64 data + 16 CRC, then `done` on the next cycle.
- Write, zero waits, busy released immediately: 48 + 8 + 8 gap + 8 token + 64 + 16 + 8 dresp + 1 busy-high sample, then `done`.
- `done` and `err` are registered outputs, not combinational from `MISO`.

## Configuration
- `SD_RD_CRC_CHECK_EN` defined: RCRC compares the received CRC16 against CRC16 computed over the 64 received bits. On mismatch, `done` with `err`=1 and `rd_data` is not updated.
- Undefined: the 16 CRC bits are clocked in and discarded, no compare logic is synthesized, and read `err` comes only from R1 or timeout.

## Test plan
- Read, addr=0x0000, card data 0x0123456789ABCDEF: MOSI frame 0x51_00000000_55; `rd_data`=0x0123456789ABCDEF; `done`=1; `err`=0.
- Write, addr=0x1234, wr_data=0xDEADBEEF00C0FFEE: MOSI frame starts 0x58_00001234; data follows token 0xFE; card model stores 0xDEADBEEF00C0FFEE; `err`=0.
- R1=0x04 returned for the read command → `done`=1, `err`=1, `rd_data` unchanged, `MOSI` high.
- MISO held high for more than 255 cycles in WAIT_R1 → `done` with `err`=1 at timeout+1; next `start` runs normally.
- Read with a corrupted CRC16: with `SD_RD_CRC_CHECK_EN`, `err`=1; without it, `err`=0 and `rd_data` updated.
- `rst` asserted at data bit 30 of a write → next cycle `MOSI`=1, `busy`=0, no `done`. Second `start` pulsed while `busy` → no effect.
